// File: rtl/temp_display_driver_if.sv
// Reading/display bundle between the thermometer stage, the display driver and the board pins.
interface temp_display_driver_if;
    logic [6:0] DEGREE_I;
    logic       VALID_I;
    logic [6:0] SEG_O;
    logic [2:0] ANODE_O;
    logic       BUSY_O;
    logic       UPDATE_O;
    logic       ALARM_O;

    modport master (
        output DEGREE_I, VALID_I,
        input  SEG_O, ANODE_O, BUSY_O, UPDATE_O, ALARM_O
    );

    modport slave (
        input  DEGREE_I, VALID_I,
        output SEG_O, ANODE_O, BUSY_O, UPDATE_O, ALARM_O
    );
endinterface

// File: rtl/temp_display_driver.sv
// Celsius reading -> 3-digit BCD (sequential double-dabble) -> multiplexed active-low 7-segment display.
// Optional build macro TEMP_DISP_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module temp_display_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int ALARM_THRESH = 80
) (
    input  logic CLK_I,
    input  logic RST_I,
    temp_display_driver_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic             prev_valid;
    logic [6:0]       bin_r, val_r;
    logic [11:0]      bcd_r, disp_r;
    logic [2:0]       iter_r;
    logic             alarm_r;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [6:0]       seg_r, digit_seg;
    logic [2:0]       anode_r;
    logic [3:0]       nib;
    logic             blank;
    logic             capture, busy, update;

    function automatic logic [6:0] sat100(input logic [6:0] d);
        return (d > 7'd100) ? 7'd100 : d;
    endfunction

    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge CLK_I) begin
        if (RST_I) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        busy    = 1'b0;
        update  = 1'b0;
        case (state_q)
            IDLE: begin
                // Rising edges arriving while not idle are simply lost.
                if (bus.VALID_I && !prev_valid) begin
                    capture = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (iter_r == 3'd6) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                update  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            prev_valid <= 1'b0;
            iter_r     <= 3'd0;
            alarm_r    <= 1'b0;
            disp_r     <= 12'd0;
        end else begin
            prev_valid <= bus.VALID_I;
            if (capture)               iter_r <= 3'd0;
            else if (state_q == CONV)  iter_r <= iter_r + 3'd1;
            if (state_q == DONE) begin
                disp_r  <= bcd_r;
                alarm_r <= (int'(val_r) >= ALARM_THRESH);
            end
        end
    end

    // Conversion datapath: adjust-then-shift, one bit per CONV cycle.
    always_ff @(posedge CLK_I) begin
        if (capture) begin
            bin_r <= sat100(bus.DEGREE_I);
            val_r <= sat100(bus.DEGREE_I);
            bcd_r <= 12'd0;
        end else if (state_q == CONV) begin
            {bcd_r, bin_r} <= {dabble_adj(bcd_r), bin_r} << 1;
        end
    end

    always_comb begin
        nib   = disp_r[3:0];
        blank = 1'b0;
        case (digit_idx)
            2'd1: begin
                nib = disp_r[7:4];
`ifdef TEMP_DISP_LEADING_ZERO_BLANK_EN
                blank = (disp_r[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                nib = disp_r[11:8];
`ifdef TEMP_DISP_LEADING_ZERO_BLANK_EN
                blank = (disp_r[11:8] == 4'd0);
`endif
            end
            default: ;
        endcase
        digit_seg = blank ? 7'b1111111 : seg7(nib);
    end

    // Anode and segment pattern share one register stage so they switch on the same edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            anode_r   <= 3'b110;
            seg_r     <= 7'b1000000;
        end else begin
            if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anode_r <= ~(3'b001 << digit_idx);
            seg_r   <= digit_seg;
        end
    end

    assign bus.SEG_O    = seg_r;
    assign bus.ANODE_O  = anode_r;
    assign bus.BUSY_O   = busy;
    assign bus.UPDATE_O = update;
    assign bus.ALARM_O  = alarm_r;
endmodule

// File: tb/tb_temp_display_driver.sv
// Scoreboard bench for temp_display_driver: directed readings, monitor checks each UPDATE_O.
module tb_temp_display_driver;
    localparam int SCAN_DIV     = 4;
    localparam int ALARM_THRESH = 80;

    typedef struct {
        int h;
        int t;
        int o;
        int alarm;
        int cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    temp_display_driver_if bus ();

    temp_display_driver #(
        .SCAN_DIV(SCAN_DIV),
        .ALARM_THRESH(ALARM_THRESH)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int exp_seg(input int pos, input exp_t e);
`ifdef TEMP_DISP_LEADING_ZERO_BLANK_EN
        if (pos == 2 && e.h == 0) return 7'b1111111;
        if (pos == 1 && e.h == 0 && e.t == 0) return 7'b1111111;
`endif
        if (pos == 0) return pat(e.o);
        if (pos == 1) return pat(e.t);
        return pat(e.h);
    endfunction

    // Monitor: pops one expectation per UPDATE_O pulse and checks timing, alarm and scanned digits.
    initial begin
        int   run;
        exp_t e;
        int   seen [3];
        bit   got  [3];
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.BUSY_O === 1'b1) run++;
            else                     run = 0;
            if (bus.UPDATE_O === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("capture_to_update_latency", cyc - e.cap, 8);
                    chk("busy_length", run, 8);
                    @(negedge clk);
                    run = 0;
                    chk("update_width", int'(bus.UPDATE_O), 0);
                    chk("alarm", int'(bus.ALARM_O), e.alarm);
                    for (int p = 0; p < 3; p++) begin
                        got[p]  = 1'b0;
                        seen[p] = -1;
                    end
                    for (int k = 0; k < 3*SCAN_DIV + 1; k++) begin
                        @(negedge clk);
                        case (bus.ANODE_O)
                            3'b110: begin seen[0] = int'(bus.SEG_O); got[0] = 1'b1; end
                            3'b101: begin seen[1] = int'(bus.SEG_O); got[1] = 1'b1; end
                            3'b011: begin seen[2] = int'(bus.SEG_O); got[2] = 1'b1; end
                            default: chk("anode_one_hot", int'(bus.ANODE_O), 3'b110);
                        endcase
                    end
                    for (int p = 0; p < 3; p++)
                        chk($sformatf("seg_digit%0d", p), got[p] ? seen[p] : -1, exp_seg(p, e));
                end
            end
        end
    end

    task automatic apply(input int deg, input int h, input int t, input int o,
                         input int al, input int hold);
        exp_t e;
        @(negedge clk);
        bus.DEGREE_I = 7'(deg);
        bus.VALID_I  = 1'b1;
        e = '{h, t, o, al, cyc};
        q.push_back(e);
        repeat (hold) @(negedge clk);
        bus.VALID_I = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst          = 1'b1;
        bus.DEGREE_I = 7'd0;
        bus.VALID_I  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",   int'(bus.BUSY_O),   0);
        chk("rst_update", int'(bus.UPDATE_O), 0);
        chk("rst_alarm",  int'(bus.ALARM_O),  0);
        chk("rst_anode",  int'(bus.ANODE_O),  3'b110);
        chk("rst_seg",    int'(bus.SEG_O),    7'b1000000);
        @(negedge clk);
        chk("scan_anode0", int'(bus.ANODE_O), 3'b110);
        repeat (SCAN_DIV) @(negedge clk);
        chk("scan_anode1", int'(bus.ANODE_O), 3'b101);
        repeat (SCAN_DIV) @(negedge clk);
        chk("scan_anode2", int'(bus.ANODE_O), 3'b011);
        repeat (4) @(negedge clk);

        apply(57,  0, 5, 7, 0, 5);
        apply(100, 1, 0, 0, 1, 2);
        apply(79,  0, 7, 9, 0, 2);
        apply(80,  0, 8, 0, 1, 2);
        apply(120, 1, 0, 0, 1, 2);

        // Reset four cycles into a conversion; VALID_I stays high across the release.
        @(negedge clk);
        bus.DEGREE_I = 7'd45;
        bus.VALID_I  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.DEGREE_I = 7'd63;
        @(negedge clk);
        chk("midrst_busy",  int'(bus.BUSY_O),   0);
        chk("midrst_update", int'(bus.UPDATE_O), 0);
        chk("midrst_alarm", int'(bus.ALARM_O),  0);
        chk("midrst_anode", int'(bus.ANODE_O),  3'b110);
        chk("midrst_seg",   int'(bus.SEG_O),    7'b1000000);
        rst = 1'b0;
        e = '{0, 6, 3, 0, cyc};
        q.push_back(e);
        repeat (32) @(negedge clk);
        bus.VALID_I = 1'b0;
        repeat (4) @(negedge clk);

        // Second rising edge three cycles after capture must be dropped.
        @(negedge clk);
        bus.DEGREE_I = 7'd45;
        bus.VALID_I  = 1'b1;
        e = '{0, 4, 5, 0, cyc};
        q.push_back(e);
        @(negedge clk);
        bus.VALID_I = 1'b0;
        repeat (2) @(negedge clk);
        bus.DEGREE_I = 7'd12;
        bus.VALID_I  = 1'b1;
        repeat (10) @(negedge clk);
        bus.VALID_I = 1'b0;
        repeat (32) @(negedge clk);

        apply(7, 0, 0, 7, 0, 3);
        apply(0, 0, 0, 0, 0, 1);

        repeat (10) @(negedge clk);
        chk("all_updates_seen", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end
endmodule
